ex_iter_unit: RTL and testbench

EX_ITER_UNIT -- requirements
Module: ex_iter_unit

---
 rtl/ex_iter_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_ex_iter_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_iter_unit.sv
// ex_iter_unit: single-cycle ALU with an iterative shift-add multiplier, an optional restoring divider and HI/LO.
// Define EX_ITER_DIV_EN to build the divider; without it DIV/DIVU complete in one cycle with result 0.
module ex_iter_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                op,
    input  logic [4:0]                shamt,
    input  logic [DATA_WIDTH-1:0]     operand_1,
    input  logic [DATA_WIDTH-1:0]     operand_2,
    input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo,
    output logic                      busy,
    input  logic                      flush
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(W);

    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUBU  = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_SLLV  = 5'd12;
    localparam logic [4:0] OP_SRLV  = 5'd13;
    localparam logic [4:0] OP_SRAV  = 5'd14;
    localparam logic [4:0] OP_MULT  = 5'd15;
    localparam logic [4:0] OP_MULTU = 5'd16;
    localparam logic [4:0] OP_DIV   = 5'd17;
    localparam logic [4:0] OP_MFHI  = 5'd19;
    localparam logic [4:0] OP_MFLO  = 5'd20;
    localparam logic [4:0] OP_MTHI  = 5'd21;
    localparam logic [4:0] OP_MTLO  = 5'd22;
`ifdef EX_ITER_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'd18;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} state_e;

    state_e          state, state_next;
    logic [CW-1:0]   count;
    logic            last;
    logic            accept;
    logic            is_mul, is_div;
    logic [W-1:0]    alu_res;
    logic [SW-1:0]   var_sh;

    logic            op_signed, sign_1, sign_2;
    logic [W-1:0]    mag_1, mag_2;

    logic [2*W-1:0]  mul_acc, mul_cand, mul_sum, mul_prod;
    logic [W-1:0]    mul_plier;
    logic            mul_neg;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign busy     = (state == S_MUL) || (state == S_DIV);
    assign last     = (count == CW'(W - 1));
    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    assign var_sh   = operand_1[SW-1:0];

`ifdef EX_ITER_DIV_EN
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
`else
    assign is_div   = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADDU: alu_res = operand_1 + operand_2;
            OP_SUBU: alu_res = operand_1 - operand_2;
            OP_AND:  alu_res = operand_1 & operand_2;
            OP_OR:   alu_res = operand_1 | operand_2;
            OP_XOR:  alu_res = operand_1 ^ operand_2;
            OP_NOR:  alu_res = ~(operand_1 | operand_2);
            OP_SLT:  alu_res = W'($signed(operand_1) < $signed(operand_2));
            OP_SLTU: alu_res = W'(operand_1 < operand_2);
            OP_SLL:  alu_res = operand_2 << shamt;
            OP_SRL:  alu_res = operand_2 >> shamt;
            OP_SRA:  alu_res = W'($signed(operand_2) >>> shamt);
            OP_SLLV: alu_res = operand_2 << var_sh;
            OP_SRLV: alu_res = operand_2 >> var_sh;
            OP_SRAV: alu_res = W'($signed(operand_2) >>> var_sh);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Signed MULT/DIV run on magnitudes; the sign is restored when the last step retires.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        sign_1    = op_signed && operand_1[W-1];
        sign_2    = op_signed && operand_2[W-1];
        mag_1     = sign_1 ? -operand_1 : operand_1;
        mag_2     = sign_2 ? -operand_2 : operand_2;
    end

    always_comb begin
        mul_sum  = mul_acc + (mul_plier[0] ? mul_cand : '0);
        mul_prod = mul_neg ? -mul_sum : mul_sum;
    end

`ifdef EX_ITER_DIV_EN
    logic [W-1:0] div_rem, div_quo, div_sor;
    logic         div_neg_q, div_neg_r, div_zero;
    logic [W:0]   div_shift, div_trial;
    logic [W-1:0] div_rem_next, div_quo_next, div_q_fin, div_r_fin;

    // A zero divisor never borrows, so the quotient saturates to all ones and the remainder is the dividend.
    always_comb begin
        div_shift = {div_rem, div_quo[W-1]};
        div_trial = div_shift - {1'b0, div_sor};
        if (div_trial[W]) begin
            div_rem_next = div_shift[W-1:0];
            div_quo_next = {div_quo[W-2:0], 1'b0};
        end else begin
            div_rem_next = div_trial[W-1:0];
            div_quo_next = {div_quo[W-2:0], 1'b1};
        end
        div_q_fin = div_zero ? '1 : (div_neg_q ? -div_quo_next : div_quo_next);
        div_r_fin = div_neg_r ? -div_rem_next : div_rem_next;
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mul)      state_next = S_MUL;
                else if (accept && is_div) state_next = S_DIV;
            end
            S_MUL:  if (last) state_next = S_HOLD;
`ifdef EX_ITER_DIV_EN
            S_DIV:  if (last) state_next = S_HOLD;
`endif
            S_HOLD: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid          <= 1'b0;
            result             <= '0;
            reg_write_addr_out <= '0;
            hi                 <= '0;
            lo                 <= '0;
            count              <= '0;
            mul_acc            <= '0;
            mul_cand           <= '0;
            mul_plier          <= '0;
            mul_neg            <= 1'b0;
`ifdef EX_ITER_DIV_EN
            div_rem            <= '0;
            div_quo            <= '0;
            div_sor            <= '0;
            div_neg_q          <= 1'b0;
            div_neg_r          <= 1'b0;
            div_zero           <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            reg_write_addr_out <= reg_write_addr_in;
            count              <= '0;
            if (is_mul || is_div) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                result    <= alu_res;
            end
            if (op == OP_MTHI) hi <= operand_1;
            if (op == OP_MTLO) lo <= operand_1;
            mul_acc   <= '0;
            mul_cand  <= {{W{1'b0}}, mag_1};
            mul_plier <= mag_2;
            mul_neg   <= sign_1 ^ sign_2;
`ifdef EX_ITER_DIV_EN
            div_rem   <= '0;
            div_quo   <= mag_1;
            div_sor   <= mag_2;
            div_neg_q <= sign_1 ^ sign_2;
            div_neg_r <= sign_1;
            div_zero  <= (operand_2 == '0);
`endif
        end else if (state == S_MUL) begin
            count     <= count + 1'b1;
            mul_acc   <= mul_sum;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            if (last) begin
                hi        <= mul_prod[2*W-1:W];
                lo        <= mul_prod[W-1:0];
                result    <= mul_prod[W-1:0];
                out_valid <= 1'b1;
            end
`ifdef EX_ITER_DIV_EN
        end else if (state == S_DIV) begin
            count   <= count + 1'b1;
            div_rem <= div_rem_next;
            div_quo <= div_quo_next;
            if (last) begin
                hi        <= div_r_fin;
                lo        <= div_q_fin;
                result    <= div_q_fin;
                out_valid <= 1'b1;
            end
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_iter_unit.sv
// Self-checking bench for ex_iter_unit at W=32: directed corner cases plus random ops against an arithmetic model.
module tb_ex_iter_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic [4:0]  reg_write_addr_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        flush = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    ex_iter_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .shamt(shamt), .operand_1(operand_1), .operand_2(operand_2),
        .reg_write_addr_in(reg_write_addr_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .reg_write_addr_out(reg_write_addr_out), .hi(hi), .lo(lo),
        .busy(busy), .flush(flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operation, waits (bounded) for in_ready, and returns 1 time unit after the accept edge.
    task automatic send(input logic [4:0] o, input logic [4:0] sh, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        in_valid = 1'b1; op = o; shamt = sh; operand_1 = a; operand_2 = b; reg_write_addr_in = tag;
        #1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("ready_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] ref_single(input logic [4:0] o, input logic [4:0] sh,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] h, input logic [31:0] l);
        longint sb, d, q;
        longint unsigned ub, p;
        int s;
        s  = (o >= 5'd12) ? int'(a[4:0]) : int'(sh);
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        d  = longint'(1) << s;
        case (o)
            5'd1:  return a + b;
            5'd2:  return a - b;
            5'd3:  return a & b;
            5'd4:  return a | b;
            5'd5:  return a ^ b;
            5'd6:  return ~(a | b);
            5'd7:  return (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
            5'd8:  return ({32'b0, a} < ub) ? 32'd1 : 32'd0;
            5'd9, 5'd12: begin p = ub * longint'(d); return p[31:0]; end
            5'd10, 5'd13: begin p = ub / longint'(d); return p[31:0]; end
            5'd11, 5'd14: begin
                q = sb / d;
                if (sb < 0 && (sb % d) != 0) q = q - 1;
                return q[31:0];
            end
            5'd19: return h;
            5'd20: return l;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_single(input string tag, input logic [4:0] o, input logic [4:0] sh,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        logic [31:0] e;
        e = ref_single(o, sh, a, b, exp_hi, exp_lo);
        send(o, sh, a, b, t);
        if (o == 5'd21) exp_hi = a;
        if (o == 5'd22) exp_lo = a;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (o != 5'd21 && o != 5'd22) check({tag, "_result"}, 64'(result), 64'(e));
        check({tag, "_tag"}, 64'(reg_write_addr_out), 64'(t));
    endtask

    // Iterative op: out_valid must stay low through cycle W and rise exactly at cycle W+1.
    task automatic do_iter(input string tag, input logic [4:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] t);
        logic [63:0] e;
        if (o == 5'd15 || o == 5'd16) e = ref_mul(o == 5'd15, a, b);
        else                          e = ref_div(o == 5'd17, a, b);
        send(o, 5'd0, a, b, t);
        for (int k = 1; k < 32; k++) step();
        check({tag, "_early"}, 64'(out_valid), 64'd0);
        step();
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hilo"}, {hi, lo}, e);
        check({tag, "_result"}, 64'(result), 64'(e[31:0]));
        check({tag, "_tag"}, 64'(reg_write_addr_out), 64'(t));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra, rb, save_res;

        // Reset values, held across two edges.
        #1;
        check("rst_state", {28'b0, out_valid, busy, in_ready, 1'b0, result}, {28'b0, 4'b0010, 32'd0});
        step();
        step();
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_tag", 64'(reg_write_addr_out), 64'd0);

        // First edge after deassertion accepts; ADDU wraps modulo 2^32.
        rst_n = 1'b1;
        do_single("addu_wrap", 5'd1, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
        do_single("slt_neg", 5'd7, 5'd0, 32'h8000_0000, 32'd1, 5'd4);
        do_single("sltu_big", 5'd8, 5'd0, 32'h8000_0000, 32'd1, 5'd5);
        do_single("sra_4", 5'd11, 5'd4, 32'd0, 32'h8000_0000, 5'd6);
        do_single("srav_24", 5'd14, 5'd0, 32'h24, 32'h8000_0000, 5'd7);
        do_single("mthi", 5'd21, 5'd0, 32'h1234_5678, 32'd0, 5'd1);
        do_single("mtlo", 5'd22, 5'd0, 32'h9ABC_DEF0, 32'd0, 5'd2);
        check("mt_hilo", {hi, lo}, {exp_hi, exp_lo});

        // MULT with the full cycle-by-cycle handshake profile.
        send(5'd15, 5'd0, 32'hFFFF_FFFE, 32'd3, 5'd9);
        for (int k = 1; k <= 32; k++) begin
            check("mult_busy", {62'b0, busy, in_ready}, 64'b10);
            check("mult_nov", 64'(out_valid), 64'd0);
            step();
        end
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFA;
        check("mult_valid", 64'(out_valid), 64'd1);
        check("mult_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("mult_result", 64'(result), 64'(exp_lo));
        check("mult_busy_done", 64'(busy), 64'd0);
        step();

        do_iter("multu_max", 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        do_iter("mult_minmin", 5'd15, 32'h8000_0000, 32'h8000_0000, 5'd11);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_iter("mul_rand", (i % 2 == 0) ? 5'd15 : 5'd16, ra, rb, 5'($urandom));
        end

`ifdef EX_ITER_DIV_EN
        do_iter("div_neg7_2", 5'd17, 32'hFFFF_FFF9, 32'd2, 5'd12);
        check("div_req_val", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_iter("divu_5_0", 5'd18, 32'd5, 32'd0, 5'd13);
        check("divu0_req_val", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        do_iter("div_neg_0", 5'd17, 32'hFFFF_FF00, 32'd0, 5'd14);
        do_iter("div_ovf", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            do_iter("div_rand", (i % 2 == 0) ? 5'd17 : 5'd18, ra, rb, 5'($urandom));
        end
`else
        send(5'd17, 5'd0, 32'd7, 32'd2, 5'd12);
        check("div_off_valid", 64'(out_valid), 64'd1);
        check("div_off_result", 64'(result), 64'd0);
        check("div_off_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("div_off_busy", 64'(busy), 64'd0);
`endif

        // Random single-cycle ops, including undefined opcodes and HI/LO moves.
        for (int i = 0; i < 48; i++) begin
            ro = 5'($urandom_range(0, 31));
            if (ro >= 5'd15 && ro <= 5'd18) ro = ro + 5'd8;
            ra = $urandom;
            rb = (i % 7 == 0) ? ra : $urandom;
            do_single("rand", ro, 5'($urandom), ra, rb, 5'($urandom));
        end

        // Back-pressure: result held, no accept, then MFLO goes in the cycle of release.
        step();
        out_ready = 1'b0;
        do_single("bp_addu", 5'd1, 5'd0, 32'd100, 32'd23, 5'd17);
        save_res = 32'd123;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold", {out_valid, in_ready, reg_write_addr_out, result},
                  {1'b1, 1'b0, 5'd17, save_res});
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = 5'd20; operand_1 = '0; operand_2 = '0; reg_write_addr_in = 5'd18;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_mflo", {out_valid, reg_write_addr_out, result}, {1'b1, 5'd18, exp_lo});

        // Flush at cycle 10 of MULTU: abort, HI/LO untouched, nothing completes later.
        send(5'd16, 5'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd19);
        for (int k = 1; k < 10; k++) step();
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", {61'b0, busy, out_valid, in_ready}, 64'b001);
        check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        for (int k = 0; k < 34; k++) step();
        check("flush_no_late", {out_valid, hi, lo}, {1'b0, exp_hi, exp_lo});

        // Flush wins over a simultaneous accept.
        in_valid = 1'b1; op = 5'd1; operand_1 = 32'd1; operand_2 = 32'd1; reg_write_addr_in = 5'd20;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_accept", {62'b0, out_valid, busy}, 64'd0);

        // Asynchronous reset mid-iteration clears everything without waiting for an edge.
`ifdef EX_ITER_DIV_EN
        send(5'd17, 5'd0, 32'd1000, 32'd7, 5'd21);
`else
        send(5'd15, 5'd0, 32'd1000, 32'd7, 5'd21);
`endif
        for (int k = 1; k < 6; k++) step();
        check("rst_mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_clear", {busy, out_valid, in_ready, reg_write_addr_out, result},
              {1'b0, 1'b0, 1'b1, 5'd0, 32'd0});
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        step();
        rst_n = 1'b1;
        do_single("post_rst_mfhi", 5'd19, 5'd0, 32'd0, 32'd0, 5'd22);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
